// File: rtl/paridade_pkg.sv
// Shared definitions for the paridade arbiter: FSM encodings, default word width,
// statistics counter width and a saturating increment helper.
package paridade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int STAT_W     = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/paridade_arbitro_paridade.sv
// Shared combinational parity unit: XOR-reduction of the input word.
// Latency: zero (purely combinational). Backpressure: none, no handshake.
module paridade #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_in,
  output logic              parity_out
);

  assign parity_out = ^data_in;

endmodule

// File: rtl/paridade_arbitro.sv
// Round-robin arbiter sharing one parity unit between N_REQ requesters; optional stats via PARIDADE_STATS_EN.
// Latency: accept at cycle t, result valid after the t+2 edge; one word per 3 cycles.
// Backpressure: result held until res_ready; no grant is issued until the result is taken.
module paridade_arbitro
  import paridade_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PAR_ODD = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      res_valid,
  output logic                      res_parity,
  output logic [$clog2(N_REQ)-1:0]  res_id,
  input  logic                      res_ready,
  output logic                      busy
`ifdef PARIDADE_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_odd_cnt,
  output logic [STAT_W-1:0]         stat_total_cnt
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic [DATA_W-1:0] data_q;
  logic              par_raw;
  logic              par_odd_b;
  logic              hs;
  int                idx_i;

  assign par_odd_b = (PAR_ODD != 0);
  assign hs        = res_valid && res_ready;
  assign busy      = (state_q != IDLE);
  assign res_id    = id_q;

  paridade #(.DATA_W(DATA_W)) u_paridade (
    .data_in    (data_q),
    .parity_out (par_raw)
  );

  // Scan from the farthest candidate back to ptr so the closest one at/after ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx_i     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_i = int'(ptr_q) + k;
      if (idx_i >= N_REQ) idx_i = idx_i - N_REQ;
      if (req_valid[idx_i]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_i[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          state_d            = CALC;
        end
      end
      CALC:    state_d = RESP;
      RESP:    if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      id_q       <= '0;
      data_q     <= '0;
      res_valid  <= 1'b0;
      res_parity <= 1'b0;
    end else begin
      if (state_q == IDLE && gnt_found) begin
        data_q <= req_data[gnt_idx*DATA_W +: DATA_W];
        id_q   <= gnt_idx;
      end
      if (state_q == CALC) begin
        res_parity <= par_raw ^ par_odd_b;
        res_valid  <= 1'b1;
      end
      if (state_q == RESP && hs) begin
        res_valid <= 1'b0;
        ptr_q     <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

`ifdef PARIDADE_STATS_EN
  // res_parity already carries the odd-parity inversion; undo it to count raw XOR results.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_odd_cnt   <= '0;
      stat_total_cnt <= '0;
    end else if (hs) begin
      stat_total_cnt <= sat_inc(stat_total_cnt);
      if (res_parity ^ par_odd_b) stat_odd_cnt <= sat_inc(stat_odd_cnt);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_paridade_arbitro.sv
// Scoreboard bench for paridade_arbitro: even and odd parity instances share stimulus; stats checked when PARIDADE_STATS_EN is defined.
module tb_paridade_arbitro;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_data;
  logic          res_ready;

  logic [N-1:0]  req_ready, req_ready_o;
  logic          res_valid, res_valid_o;
  logic          res_parity, res_parity_o;
  logic [1:0]    res_id, res_id_o;
  logic          busy, busy_o;
`ifdef PARIDADE_STATS_EN
  logic [15:0]   stat_odd_cnt, stat_total_cnt, stat_odd_cnt_o, stat_total_cnt_o;
`endif

  paridade_arbitro #(.N_REQ(N), .DATA_W(W), .PAR_ODD(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_parity(res_parity),
    .res_id(res_id), .res_ready(res_ready), .busy(busy)
`ifdef PARIDADE_STATS_EN
    , .stat_odd_cnt(stat_odd_cnt), .stat_total_cnt(stat_total_cnt)
`endif
  );

  paridade_arbitro #(.N_REQ(N), .DATA_W(W), .PAR_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_o), .res_valid(res_valid_o), .res_parity(res_parity_o),
    .res_id(res_id_o), .res_ready(res_ready), .busy(busy_o)
`ifdef PARIDADE_STATS_EN
    , .stat_odd_cnt(stat_odd_cnt_o), .stat_total_cnt(stat_total_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit par;
  } exp_t;

  exp_t     sb[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  bit       armed = 0;
  bit [N-1:0] persist = '0;

  // Reference model state: busy from grant until result handshake, fixed 2-cycle latency.
  bit       m_busy = 0;
  int       m_ptr = 0;
  int       m_acc = 0;
  int       m_id = 0;
  bit       m_par = 0;
  int       m_tot = 0;
  int       m_odd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    int g;
    int idx;
    bit exp_rv;
    logic [N-1:0] exp_ready;
    logic [W-1:0] w;
    exp_rv = m_busy && (cyc >= m_acc + 2);
    g = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    if (armed) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("req_ready_odd", 32'(req_ready_o), 32'(exp_ready));
      chk("res_valid", 32'(res_valid), 32'(exp_rv));
      chk("res_valid_odd", 32'(res_valid_o), 32'(exp_rv));
      chk("busy", 32'(busy), 32'(m_busy));
`ifdef PARIDADE_STATS_EN
      chk("stat_total", 32'(stat_total_cnt), 32'(m_tot));
      chk("stat_odd", 32'(stat_odd_cnt), 32'(m_odd));
      chk("stat_total_odd", 32'(stat_total_cnt_o), 32'(m_tot));
      chk("stat_odd_odd", 32'(stat_odd_cnt_o), 32'(m_odd));
`endif
    end
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_tot = 0; m_odd = 0;
      sb.delete();
    end else if (g >= 0) begin
      w = req_data[g*W +: W];
      m_busy = 1; m_acc = cyc; m_id = g;
      m_par = ($countones(w) % 2) == 1;
      sb.push_back('{id: g, par: m_par});
    end else if (exp_rv && res_ready) begin
      m_busy = 0;
      m_ptr = (m_id + 1) % N;
      if (m_tot < 65535) m_tot++;
      if (m_par && m_odd < 65535) m_odd++;
    end
  end

  always @(negedge clk) begin
    if (armed && !rst && res_valid) begin
      if (sb.size() == 0) begin
        chk("res_unexpected", 32'(res_valid), 32'd0);
      end else begin
        chk("res_id", 32'(res_id), 32'(sb[0].id));
        chk("res_parity", 32'(res_parity), 32'(sb[0].par));
        chk("res_id_odd", 32'(res_id_o), 32'(sb[0].id));
        chk("res_parity_odd", 32'(res_parity_o), 32'(!sb[0].par));
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick(input bit rmode);
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && !persist[i]) req_valid[i] = 1'b0;
    if (rmode) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_data[i*W +: W] = W'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; persist = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] words [3];
    rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_parity", 32'(res_parity), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    armed = 1;

    // single request, latency check
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 4'b0001; req_data[7:0] = 8'b0000_0111; res_ready = 1'b1;
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("t1_calc_valid", 32'(res_valid), 32'd0);
    chk("t1_calc_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    chk("t1_res_parity", 32'(res_parity), 32'd1);
    chk("t1_res_id", 32'(res_id), 32'd0);
    @(posedge clk); #1;

    // all requesters continuously valid: rotation 0,1,2,3,0
    req_data = 32'h0F07_0301; persist = 4'hF; req_valid = 4'hF;
    repeat (15) tick(0);
    persist = '0; req_valid = '0;
    repeat (4) tick(0);

    // stalled result, competing request must not be granted
    req_valid = 4'b0010; req_data[15:8] = 8'h55; res_ready = 1'b0;
    tick(0);
    req_valid = 4'b1000; req_data[31:24] = 8'hA1;
    repeat (7) tick(0);
    @(negedge clk);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    chk("t3_stall_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    repeat (6) tick(0);

    // pointer wrap with odd parity on 8'hFF
    req_valid = 4'b0100; req_data[23:16] = 8'h12;
    repeat (4) tick(0);
    req_valid = 4'b0001; req_data[7:0] = 8'hFF;
    @(negedge clk);
    chk("t4_wrap_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_even_ff", 32'(res_parity), 32'd0);
    chk("t4_odd_ff", 32'(res_parity_o), 32'd1);
    repeat (2) tick(0);

    // reset while in CALC
    req_valid = 4'b0010; req_data[15:8] = 8'h01;
    tick(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 32'(res_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t5_ptr0_grant", 32'(req_ready), 32'd2);
    tick(0);
    req_valid = 4'b0100;
    repeat (5) tick(0);

    // three handshakes from a clean reset for the statistics counters
    do_reset();
    rst = 1'b0;
    words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h7F;
    for (int j = 0; j < 3; j++) begin
      req_valid = 4'b0001; req_data[7:0] = words[j];
      repeat (4) tick(0);
    end
    @(negedge clk);
`ifdef PARIDADE_STATS_EN
    chk("t6_total", 32'(stat_total_cnt), 32'd3);
    chk("t6_odd", 32'(stat_odd_cnt), 32'd2);
`endif
    chk("t6_idle", 32'(busy), 32'd0);

    // randomized traffic with random backpressure
    repeat (3000) tick(1);
    persist = '0; req_valid = '0; res_ready = 1'b1;
    repeat (10) tick(0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
